multicycle_datapath: RTL
========================

Name: multicycle_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle 16-bit-instruction datapath. It contains an internal control FSM, register file, ALU and PC. It talks to instruction memory and data memory through req/ack handshakes, so slow or shared memories stall it cleanly. It adds SUB/AND/OR, a HALT state and a retired-instruction counter.

Parameters:
DW, 8, data and register width in bits.
RAW, 4, register-address width; register count = 2^RAW.
CW, 16, width of the instret counter.
Derived (localparam): IW = 3*RAW+4 (instruction width); PCW = RAW+1 (PC width).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request
imem_addr  out  PCW  fetch address (= pc)
imem_valid  in  1  imem_rdata valid this cycle
imem_rdata  in  IW  instruction word
dmem_req  out  1  data-memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  DW  data address
dmem_wdata  out  DW  store data
dmem_ack  in  1  request accepted; for loads, rdata valid
dmem_rdata  in  DW  load data
halted  out  1  core stopped in HALT
pc  out  PCW  current PC
instret  out  CW  count of retired instructions

Behaviour:
- Reset is asynchronous and active-high. All registers, pc, instret, IR, A, B and R clear to 0; state = FETCH. All outputs are 0 while reset is asserted, including in mid-handshake.
- Instruction format (bit positions relative to RAW):
  - op = [IW-1:IW-3]
  - imm flag = [3*RAW]
  - rd = [3*RAW-1:2*RAW]
  - rs = [2*RAW-1:RAW]
  - rt = [RAW-1:0]
  - imm = zero-extended [2*RAW-1:0], truncated or extended to DW
  - branch target = [3*RAW:2*RAW]
- Ops:
  - 000 ADD, 001 SUB, 101 AND, 110 OR: rd <= rs op rt. With imm=1: rd <= rd op imm.
  - 010 LOAD: rd <= dmem[R[rs]].
  - 011 STORE: dmem[R[rs]] <= R[rt].
  - 100 BEQ: if R[rs]==R[rt], pc <= target.
  - 111 HALT.
  - The imm flag is ignored for LOAD, STORE and BEQ (the flag bit is part of the BEQ target).
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid: IR <= imem_rdata, pc <= pc+1 (mod 2^PCW), go to DECODE.
  - DECODE: A <= R[rs] (or R[rd] when imm=1); B <= R[rt] (or imm). HALT op goes to HALT, otherwise to EXEC.
  - EXEC: R <= ALU(A,B). BEQ: if A==B then pc <= target; retire; go to FETCH. LOAD/STORE go to MEM; ALU ops go to WB.
  - MEM: dmem_req=1, dmem_addr=A, dmem_wdata=B, dmem_we=(op==STORE). Address and data are held stable until dmem_ack. On ack: LOAD latches R <= dmem_rdata and goes to WB; STORE retires and goes to FETCH.
  - WB: R[rd] <= R; retire; go to FETCH.
  - HALT: halted=1; no requests issued; only reset exits.
- Retire: instret increments by 1, wrapping at 2^CW. HALT does not increment it.
- Arithmetic: all ALU results are modulo 2^DW; SUB wraps. No carry or overflow outputs.
- Latency with zero-wait memories: ALU op = 4 cycles; LOAD = 5; STORE = 4; BEQ = 3.
- Handshake: imem_req is held until imem_valid and dmem_req until dmem_ack. Responses arriving without an outstanding request are ignored. Ack and req may occur in the same cycle.
- Register file: every register, including R0, is writable. A write in WB is visible to the next DECODE.

Test Plan:
- Reset during MEM with dmem_req=1: assert reset asynchronously -> dmem_req=0 before the next edge; pc=0, instret=0; next fetch is at address 0.
- Immediate ADD (RAW=4, DW=8): IR=0x1305 with R3=0 and zero-wait memory -> R3=0x05 after 4 cycles; instret=1; pc=1.
- LOAD with stall: R1=0x20, IR=0x4210, dmem_ack delayed 3 cycles -> dmem_req held with dmem_addr=0x20 for 4 cycles; dmem_rdata=0xAB gives R2=0xAB.
- BEQ: IR=0x9412. With R1==R2 -> pc=0x14. With R1!=R2 -> pc=old_pc+1. Both cases retire in 3 cycles.
- Wrap: pc=31 executing a non-branch -> next fetch address 0. SUB of R5=0x00 minus R6=0x01 -> 0xFF.
- HALT: IR=0xE000 -> halted=1, imem_req=0 indefinitely, instret unchanged; reset -> halted=0.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-instruction datapath: control FSM, register file, ALU and PC,
// with req/ack handshakes to instruction and data memory so slow memories stall it.
module multicycle_datapath #(
   parameter  int DW  = 8,
   parameter  int RAW = 4,
   parameter  int CW  = 16,
   localparam int IW  = 3*RAW+4,
   localparam int PCW = RAW+1
) (
   input  logic           clk,
   input  logic           reset,
   output logic           imem_req,
   output logic [PCW-1:0] imem_addr,
   input  logic           imem_valid,
   input  logic [IW-1:0]  imem_rdata,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic [DW-1:0]  dmem_addr,
   output logic [DW-1:0]  dmem_wdata,
   input  logic           dmem_ack,
   input  logic [DW-1:0]  dmem_rdata,
   output logic           halted,
   output logic [PCW-1:0] pc,
   output logic [CW-1:0]  instret
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_LOAD  = 3'b010;
   localparam logic [2:0] OP_STORE = 3'b011;
   localparam logic [2:0] OP_BEQ   = 3'b100;
   localparam logic [2:0] OP_AND   = 3'b101;
   localparam logic [2:0] OP_OR    = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   localparam int IMMW = (2*RAW < DW) ? 2*RAW : DW;

   logic [2:0]     state_q, state_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic [CW-1:0]  instret_q, instret_d;
   logic [IW-1:0]  ir_q, ir_d;
   logic [DW-1:0]  a_q, a_d;
   logic [DW-1:0]  b_q, b_d;
   logic [DW-1:0]  r_q, r_d;
   logic [DW-1:0]  rf_q [2**RAW];
   logic [DW-1:0]  rf_d [2**RAW];

   logic [2:0]     op;
   logic           imm_flag;
   logic           use_imm;
   logic [RAW-1:0] rd, rs, rt;
   logic [DW-1:0]  imm_ext;
   logic [PCW-1:0] target;
   logic [DW-1:0]  alu;

   always_comb begin
      op       = ir_q[IW-1 -: 3];
      imm_flag = ir_q[3*RAW];
      rd       = ir_q[3*RAW-1 -: RAW];
      rs       = ir_q[2*RAW-1 -: RAW];
      rt       = ir_q[RAW-1:0];
      target   = ir_q[3*RAW -: PCW];
      imm_ext  = '0;
      imm_ext[IMMW-1:0] = ir_q[IMMW-1:0];
      // the imm flag only selects operands for ALU ops; for BEQ it is a target bit
      use_imm  = imm_flag && (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR);
   end

   always_comb begin
      case (op)
         OP_SUB:  alu = a_q - b_q;
         OP_AND:  alu = a_q & b_q;
         OP_OR:   alu = a_q | b_q;
         default: alu = a_q + b_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instret_d = instret_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      r_d       = r_q;
      rf_d      = rf_q;
      case (state_q)
         S_FETCH: begin
            if (imem_valid) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + PCW'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = use_imm ? rf_q[rd] : rf_q[rs];
            b_d     = use_imm ? imm_ext : rf_q[rt];
            state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            r_d = alu;
            case (op)
               OP_BEQ: begin
                  if (a_q == b_q) pc_d = target;
                  instret_d = instret_q + CW'(1);
                  state_d   = S_FETCH;
               end
               OP_LOAD, OP_STORE: state_d = S_MEM;
               default:           state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (op == OP_STORE) begin
                  instret_d = instret_q + CW'(1);
                  state_d   = S_FETCH;
               end else begin
                  r_d     = dmem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_d[rd]  = r_q;
            instret_d = instret_q + CW'(1);
            state_d   = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         instret_q <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         r_q       <= '0;
         rf_q      <= '{default: '0};
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instret_q <= instret_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         r_q       <= r_d;
         rf_q      <= rf_d;
      end
   end

   // requests are masked by reset so nothing is asserted while reset is held in FETCH
   assign imem_req   = (state_q == S_FETCH) && !reset;
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_MEM) && !reset;
   assign dmem_we    = dmem_req && (op == OP_STORE);
   assign dmem_addr  = a_q;
   assign dmem_wdata = b_q;
   assign halted     = (state_q == S_HALT);
   assign pc         = pc_q;
   assign instret    = instret_q;

endmodule
